snow64_icache_mem_responder: RTL and testbench

- Memory-side responder for the instruction cache's line-fill interface.
- Accepts a line-fill request (req, addr) from the icache and fetches the 256-bit line from a narrower backing memory over several word beats.
- Assembles the beats into one line and returns it to the icache as a single-cycle valid+data pulse.
- Sits between the icache and the backing memory / bus arbiter.

---
 rtl/snow64_icache_mem_responder_pkg.sv | 47 ++++
 rtl/snow64_icache_line_assembler.sv | 27 ++
 rtl/snow64_icache_mem_responder.sv | 130 +++++++++++++
 tb/tb_snow64_icache_mem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snow64_icache_mem_responder_pkg.sv
// Shared types for the icache line-fill responder: widths, beat/word types,
// FSM state enum and the partial port structs for the icache and memory sides.
package snow64_icache_mem_responder_pkg;

    localparam int WIDTH__ADDR         = 64;
    localparam int WIDTH__LINE_DATA    = 256;
    localparam int WIDTH__MEM_WORD     = 64;
    localparam int NUM_BEATS           = WIDTH__LINE_DATA / WIDTH__MEM_WORD;
    localparam int MSB_POS__BEAT_INDEX = $clog2(NUM_BEATS) - 1;
    localparam int WIDTH__LINE_OFFSET  = $clog2(WIDTH__LINE_DATA / 8);
    localparam int WIDTH__WORD_OFFSET  = $clog2(WIDTH__MEM_WORD / 8);

    typedef logic [MSB_POS__BEAT_INDEX:0]  BeatIndex;
    typedef logic [WIDTH__MEM_WORD-1:0]    MemWord;
    typedef logic [WIDTH__LINE_DATA-1:0]   LineData;
    typedef logic [WIDTH__ADDR-1:0]        CpuAddr;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitWord,
        StDeliver
    } StateMemResp;

    // Icache-facing side, named from the icache's point of view.
    typedef struct packed {
        logic   req;
        CpuAddr addr;
    } PartialPortOut_InstrCache_MemAccess;

    typedef struct packed {
        logic    valid;
        LineData data;
    } PartialPortIn_InstrCache_MemAccess;

    // Backing-memory side, named from the responder's point of view.
    typedef struct packed {
        logic   req;
        CpuAddr addr;
    } PartialPortOut_MemResp_MemRead;

    typedef struct packed {
        logic   valid;
        MemWord data;
    } PartialPortIn_MemResp_MemRead;

endpackage

// File: rtl/snow64_icache_line_assembler.sv
// Line register for the icache fill: one memory word is written into the
// selected lane per enabled cycle; the whole line is always visible.
module snow64_icache_line_assembler
    import snow64_icache_mem_responder_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_en,
    input  BeatIndex wr_lane,
    input  MemWord   wr_data,
    output LineData  line
);

    // Write the returned word into its lane; other lanes hold their value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BEATS; i++) begin
                if (wr_lane == BeatIndex'(i)) begin
                    line[i*WIDTH__MEM_WORD +: WIDTH__MEM_WORD] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/snow64_icache_mem_responder.sv
// Icache line-fill responder: takes a line request, reads the line from the
// backing memory one word at a time, and returns it as a single-cycle pulse.
// Optional: SNOW64_ICACHE_RESP_CRITICAL_WORD_FIRST_EN starts the fetch at the
// requested word (addr[4:3]) and wraps; the assembled line is the same.
module snow64_icache_mem_responder
    import snow64_icache_mem_responder_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_icache_req,
    input  logic [WIDTH__ADDR-1:0]      in_icache_addr,
    output logic                        out_icache_valid,
    output logic [WIDTH__LINE_DATA-1:0] out_icache_data,
    output logic                        out_mem_req,
    output logic [WIDTH__ADDR-1:0]      out_mem_addr,
    input  logic                        in_mem_valid,
    input  logic [WIDTH__MEM_WORD-1:0]  in_mem_data
);

    localparam CpuAddr LINE_OFFSET_MASK = CpuAddr'(WIDTH__LINE_DATA / 8 - 1);
    localparam logic [WIDTH__WORD_OFFSET-1:0] WORD_OFFSET_ZERO = '0;

    PartialPortOut_InstrCache_MemAccess icache_req_in;
    PartialPortIn_InstrCache_MemAccess  icache_resp_out;
    PartialPortOut_MemResp_MemRead      mem_rd_out;
    PartialPortIn_MemResp_MemRead       mem_rd_in;

    StateMemResp state, next_state;
    CpuAddr      base_addr;
    BeatIndex    beat, start_word, word_index;
    LineData     line_data;
    logic        latch_req, beat_inc, lane_wr, resp_valid;

    assign icache_req_in    = {in_icache_req, in_icache_addr};
    assign mem_rd_in        = {in_mem_valid, in_mem_data};
    assign icache_resp_out  = {resp_valid, line_data};
    assign out_icache_valid = icache_resp_out.valid;
    assign out_icache_data  = icache_resp_out.data;
    assign out_mem_req      = mem_rd_out.req;
    assign out_mem_addr     = mem_rd_out.addr;

`ifdef SNOW64_ICACHE_RESP_CRITICAL_WORD_FIRST_EN
    assign start_word = base_addr[WIDTH__LINE_OFFSET-1:WIDTH__WORD_OFFSET];
`else
    assign start_word = '0;
`endif

    // Word order follows the beat counter from the start word, wrapping mod NUM_BEATS.
    assign word_index = start_word + beat;

    // State register; reset abandons any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
        end else begin
            state <= next_state;
        end
    end

    // Beat counter: cleared on accepting a request, advanced per returned word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (latch_req) begin
            beat <= '0;
        end else if (beat_inc) begin
            beat <= beat + 1'b1;
        end
    end

    // Request address capture; low bits are masked when forming beat addresses.
    always_ff @(posedge clk) begin
        if (latch_req) begin
            base_addr <= icache_req_in.addr;
        end
    end

    // Next-state and output decode; requests and memory returns outside
    // their accepting state fall through to the defaults and are dropped.
    always_comb begin
        next_state = state;
        latch_req  = 1'b0;
        beat_inc   = 1'b0;
        lane_wr    = 1'b0;
        resp_valid = 1'b0;
        mem_rd_out = '0;
        case (state)
            StIdle: begin
                if (icache_req_in.req) begin
                    latch_req  = 1'b1;
                    next_state = StIssue;
                end
            end
            StIssue: begin
                mem_rd_out.req  = 1'b1;
                mem_rd_out.addr = (base_addr & ~LINE_OFFSET_MASK)
                                | CpuAddr'({word_index, WORD_OFFSET_ZERO});
                next_state      = StWaitWord;
            end
            StWaitWord: begin
                if (mem_rd_in.valid) begin
                    lane_wr = 1'b1;
                    if (beat == BeatIndex'(NUM_BEATS - 1)) begin
                        next_state = StDeliver;
                    end else begin
                        beat_inc   = 1'b1;
                        next_state = StIssue;
                    end
                end
            end
            StDeliver: begin
                resp_valid = 1'b1;
                next_state = StIdle;
            end
            default: begin
                next_state = StIdle;
            end
        endcase
    end

    snow64_icache_line_assembler u_line_assembler (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (lane_wr),
        .wr_lane (word_index),
        .wr_data (mem_rd_in.data),
        .line    (line_data)
    );

endmodule

// File: tb/tb_snow64_icache_mem_responder.sv
// Bench for the icache line-fill responder: memory model with configurable
// latency, monitor queues, and a line/address reference model.
module tb_snow64_icache_mem_responder;

    logic         clk;
    logic         rst_n = 1'b1;
    logic         in_icache_req;
    logic [63:0]  in_icache_addr;
    logic         out_icache_valid;
    logic [255:0] out_icache_data;
    logic         out_mem_req;
    logic [63:0]  out_mem_addr;
    logic         in_mem_valid;
    logic [63:0]  in_mem_data;

    logic         mem_valid_m;
    logic [63:0]  mem_data_m;
    logic         stray_valid;
    logic [63:0]  stray_data;
    int           mem_lat = 1;
    logic [63:0]  mem_salt = '0;

    int           cyc = 0;
    int           total = 0;
    int           bad = 0;

    int           req_cyc[$];
    logic [63:0]  req_addr[$];
    int           vld_cyc[$];
    logic [255:0] vld_data[$];

    assign in_mem_valid = mem_valid_m | stray_valid;
    assign in_mem_data  = stray_valid ? stray_data : mem_data_m;

    snow64_icache_mem_responder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_icache_req    (in_icache_req),
        .in_icache_addr   (in_icache_addr),
        .out_icache_valid (out_icache_valid),
        .out_icache_data  (out_icache_data),
        .out_mem_req      (out_mem_req),
        .out_mem_addr     (out_mem_addr),
        .in_mem_valid     (in_mem_valid),
        .in_mem_data      (in_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log memory requests and icache responses with their cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_mem_req === 1'b1) begin
                req_cyc.push_back(cyc);
                req_addr.push_back(out_mem_addr);
            end
            if (rst_n === 1'b1 && out_icache_valid === 1'b1) begin
                vld_cyc.push_back(cyc);
                vld_data.push_back(out_icache_data);
            end
        end
    end

    // Backing memory: word at address a is a ^ salt, returned mem_lat cycles later.
    initial begin
        logic [63:0] a;
        mem_valid_m = 1'b0;
        mem_data_m  = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_mem_req === 1'b1) begin
                a = out_mem_addr;
                repeat (mem_lat) @(posedge clk);
                #1;
                mem_valid_m = 1'b1;
                mem_data_m  = a ^ mem_salt;
                @(posedge clk);
                #1;
                mem_valid_m = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] line_base(input logic [63:0] addr);
        return addr & ~64'h1F;
    endfunction

    // Address of the k-th memory read for a request at addr.
    function automatic logic [63:0] exp_beat_addr(input logic [63:0] addr, input int k);
        int w0;
        w0 = 0;
`ifdef SNOW64_ICACHE_RESP_CRITICAL_WORD_FIRST_EN
        w0 = int'(addr[4:3]);
`endif
        return line_base(addr) + 64'((w0 + k) % 4) * 64'd8;
    endfunction

    // Expected line: lane w holds the memory word at base + 8*w.
    function automatic logic [255:0] exp_line(input logic [63:0] addr, input logic [63:0] salt);
        logic [255:0] l;
        for (int w = 0; w < 4; w++) begin
            l[w*64 +: 64] = (line_base(addr) + 64'(w) * 64'd8) ^ salt;
        end
        return l;
    endfunction

    // One fill: optional second request and stray memory pulse at cycle offsets.
    task automatic run_fill(input string tag, input logic [63:0] addr, input int lat,
                            input logic [63:0] salt, input int req2_off, input int stray_off,
                            output logic [255:0] line);
        int n;
        line     = exp_line(addr, salt);
        mem_lat  = lat;
        mem_salt = salt;
        req_cyc.delete();
        req_addr.delete();
        vld_cyc.delete();
        vld_data.delete();
        in_icache_req  = 1'b1;
        in_icache_addr = addr;
        n = cyc;
        step();
        in_icache_req  = 1'b0;
        in_icache_addr = {$urandom, $urandom};
        for (int i = 1; i <= 200; i++) begin
            if (i == req2_off) begin
                in_icache_req  = 1'b1;
                in_icache_addr = 64'h3000;
            end
            if (i == stray_off) begin
                stray_valid = 1'b1;
                stray_data  = '1;
            end
            step();
            in_icache_req = 1'b0;
            stray_valid   = 1'b0;
            if (vld_cyc.size() != 0) break;
        end
        repeat (12) step();
        chk({tag, "_nreq"}, 256'(req_cyc.size()), 256'(4));
        for (int k = 0; k < 4 && k < req_cyc.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), 256'(req_addr[k]), 256'(exp_beat_addr(addr, k)));
            chk($sformatf("%s_rcyc%0d", tag, k), 256'(req_cyc[k]), 256'(n + 1 + k * (lat + 1)));
        end
        chk({tag, "_nvld"}, 256'(vld_cyc.size()), 256'(1));
        if (vld_cyc.size() != 0) begin
            chk({tag, "_vcyc"}, 256'(vld_cyc[0]), 256'(n + 4 * (lat + 1) + 1));
            chk({tag, "_data"}, vld_data[0], line);
        end
        chk({tag, "_hold"}, out_icache_data, line);
    endtask

    initial begin
        logic [255:0] line;
        int n;
        in_icache_req  = 1'b0;
        in_icache_addr = '0;
        stray_valid    = 1'b0;
        stray_data     = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 256'(out_icache_valid), 256'(0));
        chk("rst_data", out_icache_data, 256'(0));
        chk("rst_mreq", 256'(out_mem_req), 256'(0));
        chk("rst_maddr", 256'(out_mem_addr), 256'(0));
        repeat (2) step();
        rst_n = 1'b1;
        step();

        run_fill("basic", 64'h0000_0000_1000_0044, 1, 64'h0, -1, -1, line);
        chk("basic_pattern", line, {64'h1000_0058, 64'h1000_0050, 64'h1000_0048, 64'h1000_0040});
        run_fill("lat5", 64'h2000, 5, 64'h0, -1, -1, line);
        run_fill("drop2nd", 64'h1000, 1, 64'h0, 3, -1, line);

        // Reset in the cycle after beat 1 returns, then a stray word after release.
        mem_lat  = 1;
        mem_salt = '0;
        in_icache_req  = 1'b1;
        in_icache_addr = 64'h5008;
        n = cyc;
        step();
        in_icache_req = 1'b0;
        while (cyc < n + 5) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(out_icache_valid), 256'(0));
        chk("mid_rst_data", out_icache_data, 256'(0));
        chk("mid_rst_mreq", 256'(out_mem_req), 256'(0));
        chk("mid_rst_maddr", 256'(out_mem_addr), 256'(0));
        step();
        step();
        rst_n = 1'b1;
        step();
        stray_valid = 1'b1;
        stray_data  = '1;
        step();
        stray_valid = 1'b0;
        chk("post_rst_stray_data", out_icache_data, 256'(0));
        chk("post_rst_stray_mreq", 256'(out_mem_req), 256'(0));
        chk("post_rst_stray_vld", 256'(out_icache_valid), 256'(0));
        run_fill("rst_new", 64'h4000, 1, 64'h0, -1, -1, line);
        chk("rst_new_pattern", line, {64'h4018, 64'h4010, 64'h4008, 64'h4000});

        run_fill("cwf", 64'h1000_0050, 1, 64'h0, -1, -1, line);
        run_fill("issue_stray", 64'h6000_0008, 1, {$urandom, $urandom}, -1, 1, line);

        // Stray memory words while idle must not touch the held line.
        for (int i = 0; i < 3; i++) begin
            stray_valid = 1'b1;
            stray_data  = {$urandom, $urandom};
            step();
        end
        stray_valid = 1'b0;
        chk("idle_stray_data", out_icache_data, line);
        chk("idle_stray_vld", 256'(out_icache_valid), 256'(0));
        chk("idle_stray_mreq", 256'(out_mem_req), 256'(0));

        for (int t = 0; t < 5; t++) begin
            run_fill($sformatf("rnd%0d", t), {$urandom, $urandom},
                     int'($urandom_range(1, 4)), {$urandom, $urandom}, -1, -1, line);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
